branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Branch direction predictor and resolution controller for the 5-stage RV32I pipeline.
- IF stage: looks up a PC-indexed table of 2-bit saturating counters and supplies a taken/not-taken prediction.
- EX stage: consumes the comparator's br_en result, detects mispredictions, and issues a registered flush/redirect to fetch.
- Trains the counter table on every resolved conditional branch.

Parameters:
- PHT_IDX_BITS, 6, log2 of the number of pattern-history-table entries (64 entries).
- RESET_CTR, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_pc  input  32  PC of the instruction being fetched
- if_pred_taken  output  1  combinational prediction for if_pc
- ex_valid  input  1  EX holds a real (non-bubble) instruction
- ex_stall  input  1  EX is held this cycle
- ex_is_branch  input  1  EX instruction is a conditional branch (beq..bgeu)
- ex_is_jump  input  1  EX instruction is jal/jalr (always taken)
- ex_br_en  input  1  comparator result for the EX branch
- ex_pc  input  32  PC of the EX instruction
- ex_target  input  32  computed taken target
- ex_pred_taken  input  1  prediction carried down the pipe for this instruction
- ex_pred_target  input  32  target fetch used if predicted taken
- flush  output  1  one-cycle pulse: squash IF/ID/EX-younger and redirect
- redirect_pc  output  32  correct next PC, valid while flush=1
- stat_branches  output  32  resolved conditional-branch count (optional feature)
- stat_mispredicts  output  32  mispredict count (optional feature)

Behaviour:
- Index is pc[PHT_IDX_BITS+1:2]. The table is 2^PHT_IDX_BITS x 2-bit flops.
- if_pred_taken = pht[idx(if_pc)][1]. Purely combinational, no bypass of a same-cycle update: a lookup at an index being written sees the old value.
- Resolve condition: resolve = ex_valid & ~ex_stall & ~flush.
  - The instruction in EX while flush=1 is wrong-path and is ignored entirely: no training, no stats, no new flush.
  - While stalled, evaluation is deferred; it happens exactly once, in the first cycle ex_stall=0.
- Actual outcome:
  - actual_taken = ex_is_jump | (ex_is_branch & ex_br_en)
  - correct_pc = actual_taken ? ex_target : ex_pc + 32'd4 (modulo-2^32 add; wrap at 0xFFFFFFFC gives 0x00000000)
- Misprediction: mispredict = resolve & (ex_is_branch | ex_is_jump) & ((actual_taken != ex_pred_taken) | (actual_taken & ex_pred_taken & (ex_pred_target != ex_target))).
- Flush/redirect:
  - Registered, 1-cycle latency. On the edge ending the resolve cycle: flush <= mispredict; redirect_pc <= correct_pc when mispredict, else it holds its previous value.
  - flush is never high for two consecutive cycles.
- Training:
  - On resolve & ex_is_branch, at the same edge, pht[idx(ex_pc)] += 1 if ex_br_en, else -= 1.
  - Saturates at 2'b11 and 2'b00.
  - Jumps and non-branches do not train.
- Reset: while rst=1 at an edge, flush <= 0, redirect_pc <= 0, every counter <= RESET_CTR, stats <= 0.
  - A reset asserted during a pending flush cancels it; flush is 0 in the cycle after reset.
- Non-branch, non-jump in EX: no flush, no training.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - stat_branches increments on resolve & ex_is_branch.
  - stat_mispredicts increments on any mispredict (branches and jumps).
  - Both are 32-bit, wrap on overflow, and reset to 0.
- Undefined: both ports remain in the interface, tied to 32'd0; no counter flops are synthesised.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0; all indices read counter 01.
- beq at ex_pc=0x100, ex_br_en=1, ex_pred_taken=0, ex_target=0x80 -> next cycle flush=1, redirect_pc=0x80; pht[0] becomes 10 and if_pc=0x100 then predicts taken; flush=0 the following cycle.
- Four consecutive resolved taken branches at 0x200 -> counter saturates at 11; one not-taken -> 10, prediction still taken; a correctly predicted branch produces no flush.
- ex_stall=1 for 3 cycles with a mispredicted bne (pred taken, br_en=0, ex_pc=0x300) -> no flush while stalled; flush=1 with redirect_pc=0x304 exactly one cycle after stall drops; one training step only.
- Mispredict followed by a second mispredicting branch in EX in the flush cycle -> only one flush pulse; the second branch neither trains nor counts.
- jalr with ex_pred_taken=1, ex_pred_target=0x400, ex_target=0x404 -> flush, redirect_pc=0x404; PHT unchanged. With BRANCH_STATS_EN: stat_mispredicts +1, stat_branches unchanged. rst asserted the cycle before flush would appear -> flush stays 0.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: 2-bit saturating-counter branch direction predictor
// plus EX-stage resolution with a registered flush/redirect to fetch.
// Optional build macro BRANCH_STATS_EN adds resolved-branch and mispredict
// counters; without it the stat ports are tied to zero.
//
// Handshake: there is no valid/ready pair here. An EX instruction is
// consumed exactly once, in the first cycle where ex_valid=1, ex_stall=0 and
// no flush is being issued. flush is a one-cycle pulse and redirect_pc is
// only meaningful while flush=1.
module branch_resolve_ctrl #(
  parameter int         PHT_IDX_BITS = 6,
  parameter logic [1:0] RESET_CTR    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_br_en,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;

  logic [1:0]              pht_q [PHT_ENTRIES];
  logic [1:0]              pht_d [PHT_ENTRIES];
  logic                    flush_q, flush_d;
  logic [31:0]             redirect_q, redirect_d;
  logic [PHT_IDX_BITS-1:0] if_idx, ex_idx;
  logic                    resolve, actual_taken, mispredict, train;
  logic [31:0]             correct_pc;
  logic [1:0]              ctr_old, ctr_new;

  assign if_idx        = if_pc[PHT_IDX_BITS+1:2];
  assign ex_idx        = ex_pc[PHT_IDX_BITS+1:2];
  // Lookup reads registered state only, so a same-cycle write is not bypassed.
  assign if_pred_taken = pht_q[if_idx][1];
  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;

  // Resolve the EX instruction: outcome, mispredict detection, counter training.
  always_comb begin
    resolve      = ex_valid & ~ex_stall & ~flush_q;
    actual_taken = ex_is_jump | (ex_is_branch & ex_br_en);
    correct_pc   = actual_taken ? ex_target : (ex_pc + 32'd4);
    mispredict   = resolve & (ex_is_branch | ex_is_jump) &
                   ((actual_taken != ex_pred_taken) |
                    (actual_taken & ex_pred_taken & (ex_pred_target != ex_target)));
    train        = resolve & ex_is_branch;
    ctr_old      = pht_q[ex_idx];
    ctr_new      = ctr_old;
    if (ex_br_en) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
    end
    for (int i = 0; i < PHT_ENTRIES; i++) pht_d[i] = pht_q[i];
    if (train) pht_d[ex_idx] = ctr_new;
    flush_d    = mispredict;
    redirect_d = mispredict ? correct_pc : redirect_q;
  end

  // Pattern history table and registered flush/redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redirect_q <= 32'd0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= RESET_CTR;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= pht_d[i];
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Next values of the wrapping statistics counters.
  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, train};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural model of the predictor.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_br_en;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_pht [64];
  bit          m_flush;
  logic [31:0] m_redirect;
  logic [31:0] m_br_cnt, m_mis_cnt;
  bit          m_init = 0;

  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_br_en(ex_br_en), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pidx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  // One clock cycle: drive at negedge, check prediction, step model, check
  // registered outputs just after the posedge.
  task automatic cyc(input bit r, input bit v, input bit s, input bit br,
                     input bit j, input bit en, input logic [31:0] pc,
                     input logic [31:0] tgt, input bit pt,
                     input logic [31:0] ptgt, input logic [31:0] ipc);
    bit          res, taken, mis;
    logic [31:0] cpc;
    @(negedge clk);
    rst = r; ex_valid = v; ex_stall = s; ex_is_branch = br; ex_is_jump = j;
    ex_br_en = en; ex_pc = pc; ex_target = tgt; ex_pred_taken = pt;
    ex_pred_target = ptgt; if_pc = ipc;
    #1;
    if (m_init) chk("pred", {31'd0, if_pred_taken}, {31'd0, m_pht[pidx(ipc)] >= 2});
    res   = v && !s && !m_flush;
    taken = j || (br && en);
    cpc   = taken ? tgt : pc + 32'd4;
    mis   = res && (br || j) && ((taken != pt) || (taken && pt && ptgt != tgt));
    @(posedge clk);
    #1;
    if (r) begin
      foreach (m_pht[i]) m_pht[i] = 1;
      m_flush = 0; m_redirect = 0; m_br_cnt = 0; m_mis_cnt = 0; m_init = 1;
    end else if (m_init) begin
      if (res && br) begin
        if (en && m_pht[pidx(pc)] < 3) m_pht[pidx(pc)]++;
        if (!en && m_pht[pidx(pc)] > 0) m_pht[pidx(pc)]--;
        m_br_cnt++;
      end
      if (mis) begin
        m_redirect = cpc;
        m_mis_cnt++;
      end
      m_flush = mis;
    end
    if (m_init) begin
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
      chk("redirect", redirect_pc, m_redirect);
`ifdef BRANCH_STATS_EN
      chk("stat_br", stat_branches, m_br_cnt);
      chk("stat_mis", stat_mispredicts, m_mis_cnt);
`else
      chk("stat_br", stat_branches, 32'd0);
      chk("stat_mis", stat_mispredicts, 32'd0);
`endif
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, ipc);
  endtask

  task automatic peek_pred(input string tag, input logic [31:0] ipc, input bit exp);
    if_pc = ipc;
    #1;
    chk(tag, {31'd0, if_pred_taken}, {31'd0, exp});
  endtask

  initial begin
    logic [31:0] base_br, base_mis;
    // reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    peek_pred("rst_pred_100", 32'h100, 0);
    for (int i = 0; i < 64; i++) idle(32'(i * 4));

    // taken beq predicted not-taken at 0x100
    cyc(0, 1, 0, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0, 32'h100);
    chk("tp_flush", {31'd0, flush}, 32'd1);
    chk("tp_redirect", redirect_pc, 32'h80);
    peek_pred("tp_pred_after", 32'h100, 1);
    idle(32'h100);
    chk("tp_flush_drop", {31'd0, flush}, 32'd0);

    // saturate at 0x200, then one not-taken
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 1, 0, 1, 32'h200, 32'h240, 1, 32'h240, 32'h200);
      chk("sat_noflush", {31'd0, flush}, 32'd0);
    end
    cyc(0, 1, 0, 1, 0, 0, 32'h200, 32'h240, 0, 32'h0, 32'h200);
    chk("nt_correct_noflush", {31'd0, flush}, 32'd0);
    peek_pred("sat_pred_still_taken", 32'h200, 1);

    // stalled mispredicted bne at 0x300
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 1, 0, 0, 32'h300, 32'h340, 1, 32'h340, 32'h300);
      chk("stall_noflush", {31'd0, flush}, 32'd0);
    end
    cyc(0, 1, 0, 1, 0, 0, 32'h300, 32'h340, 1, 32'h340, 32'h300);
    chk("stall_flush", {31'd0, flush}, 32'd1);
    chk("stall_redirect", redirect_pc, 32'h304);
    idle(32'h300);

    // back-to-back mispredicts: second is in EX during the flush cycle
    base_br = m_br_cnt; base_mis = m_mis_cnt;
    cyc(0, 1, 0, 1, 0, 1, 32'h500, 32'h600, 0, 32'h0, 32'h500);
    cyc(0, 1, 0, 1, 0, 1, 32'h504, 32'h700, 0, 32'h0, 32'h504);
    chk("b2b_single_pulse", {31'd0, flush}, 32'd0);
    chk("b2b_redirect_hold", redirect_pc, 32'h600);
`ifdef BRANCH_STATS_EN
    chk("b2b_br_cnt", stat_branches, base_br + 32'd1);
    chk("b2b_mis_cnt", stat_mispredicts, base_mis + 32'd1);
`endif
    peek_pred("b2b_no_train", 32'h504, 0);

    // jalr with wrong predicted target
    base_br = m_br_cnt;
    cyc(0, 1, 0, 0, 1, 0, 32'h180, 32'h404, 1, 32'h400, 32'h180);
    chk("jalr_flush", {31'd0, flush}, 32'd1);
    chk("jalr_redirect", redirect_pc, 32'h404);
    peek_pred("jalr_no_train", 32'h180, 0);
`ifdef BRANCH_STATS_EN
    chk("jalr_br_cnt", stat_branches, base_br);
`endif
    idle(32'h0);

    // not-taken at top of address space wraps
    cyc(0, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 32'h0);
    chk("wrap_redirect", redirect_pc, 32'h0000_0000);
    idle(32'h0);

    // reset in the resolve cycle cancels the pending flush
    cyc(1, 1, 0, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0, 32'h100);
    chk("rst_cancel_flush", {31'd0, flush}, 32'd0);
    peek_pred("rst_restores_ctr", 32'h100, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r, v, s, br, j, en, pt;
      logic [31:0] pc, tgt, ptgt;
      r    = ($urandom_range(0, 299) == 0);
      v    = ($urandom_range(0, 9) != 0);
      s    = ($urandom_range(0, 4) == 0);
      br   = ($urandom_range(0, 9) < 6);
      j    = !br && ($urandom_range(0, 2) == 0);
      en   = $urandom_range(0, 1);
      pt   = $urandom_range(0, 1);
      pc   = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
                                          : 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      tgt  = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
      ptgt = ($urandom_range(0, 3) == 0) ? tgt + 32'd4 : tgt;
      cyc(r, v, s, br, j, en, pc, tgt, pt, ptgt,
          32'h1000 + 32'($urandom_range(0, 15)) * 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
